// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority, secondary
// results are buffered via round-robin and drained when idle. Option: WB_ARB_KILL_EN.
module wb_port_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_wen,
    input  logic [4:0]            pipe_addr,
    input  logic [31:0]           pipe_data,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*5-1:0]  req_addr,
    input  logic [NUM_REQ*32-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rf_wen,
    output logic [4:0]            rf_addr,
    output logic [31:0]           rf_wdata,
    output logic [31:0]           pend_mask,
    output logic                  stall_req,
    output logic                  buf_full
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]           buf_addr [BUF_DEPTH];
    logic [31:0]          buf_data [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] buf_vld;
    logic [PTR_W-1:0]     rd_ptr, wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [RR_W-1:0]      rr_ptr;
    logic [STV_W-1:0]     starve_cnt;

    logic                 not_empty, head_vld, pipe_real;
    logic                 head_win, pipe_win, skip_pop, pop, push, accept;
    logic                 gnt_found;
    logic [RR_W-1:0]      gnt_idx;
    logic [4:0]           gnt_addr;
    logic [31:0]          gnt_data;
    logic [BUF_DEPTH-1:0] kill, push_mask, pop_mask;

    assign not_empty = (count != '0);
    assign head_vld  = buf_vld[rd_ptr];
    assign pipe_real = pipe_wen && (pipe_addr != 5'd0);
    assign buf_full  = (count == CNT_W'(BUF_DEPTH));

    // While stalled the pipeline is frozen, so its inputs never compete with the head.
    always_comb begin
        head_win = 1'b0;
        pipe_win = 1'b0;
        if (stall_req && not_empty) begin
            head_win = head_vld;
        end else if (pipe_real) begin
            pipe_win = 1'b1;
        end else if (not_empty) begin
            head_win = head_vld;
        end
    end

    // A squashed head leaves the FIFO without taking a port cycle.
    assign skip_pop = not_empty && !head_vld;
    assign pop      = head_win || skip_pop;

`ifdef WB_ARB_KILL_EN
    always_comb begin
        kill = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            kill[i] = pipe_win && buf_vld[i] && (buf_addr[i] == pipe_addr);
        end
    end
`else
    assign kill = '0;
`endif

    // Circular search: requesters at/after rr_ptr first, then wrap to the low indices.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        gnt_addr  = '0;
        gnt_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i] && (i >= int'(rr_ptr))) begin
                gnt_found = 1'b1;
                gnt_idx   = RR_W'(i);
                gnt_addr  = req_addr[i*5 +: 5];
                gnt_data  = req_data[i*32 +: 32];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found && req_valid[i]) begin
                gnt_found = 1'b1;
                gnt_idx   = RR_W'(i);
                gnt_addr  = req_addr[i*5 +: 5];
                gnt_data  = req_data[i*32 +: 32];
            end
        end
    end

    // Room is judged on the registered count; a same-cycle pop does not help.
    assign accept = rst_n && gnt_found && (count < CNT_W'(BUF_DEPTH));
    assign push   = accept && (gnt_addr != 5'd0);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (gnt_idx == RR_W'(i));
        end
    end

    assign push_mask = push ? (BUF_DEPTH'(1) << wr_ptr) : '0;
    assign pop_mask  = pop  ? (BUF_DEPTH'(1) << rd_ptr) : '0;

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            if (buf_vld[i] && !kill[i]) begin
                pend_mask[buf_addr[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr] <= gnt_addr;
            buf_data[wr_ptr] <= gnt_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_vld <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            rr_ptr  <= '0;
        end else begin
            buf_vld <= (buf_vld & ~kill & ~pop_mask) | push_mask;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
            if (accept) begin
                rr_ptr <= (gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + RR_W'(1);
            end
        end
    end

    // Starve counter saturates at the limit so the stall trigger stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (!not_empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
            if (stall_req) begin
                stall_req <= !(pop || !not_empty);
            end else begin
                stall_req <= (starve_cnt == STV_W'(STARVE_LIMIT)) && !pop;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_addr  <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= head_win || pipe_win;
            if (head_win) begin
                rf_addr  <= buf_addr[rd_ptr];
                rf_wdata <= buf_data[rd_ptr];
            end else if (pipe_win) begin
                rf_addr  <= pipe_addr;
                rf_wdata <= pipe_data;
            end else begin
                rf_addr  <= '0;
                rf_wdata <= '0;
            end
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Schedules the single register-file write port between the in-order pipeline writeback (writeback-unit output) and NUM_REQ long-latency requesters (mul/div unit, late load return).
- The pipeline has fixed priority.
- Secondary results are accepted by round-robin into a small FIFO and drained when the port is idle.
- A starvation counter forces a pipeline stall so buffered results always retire. A pending-register mask feeds the hazard unit.

Parameters:
- NUM_REQ, 2, number of secondary requesters (1..4)
- BUF_DEPTH, 2, holding FIFO entries (power of two, 2..8)
- STARVE_LIMIT, 4, cycles a non-empty FIFO head may wait before a stall is forced

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_wen  in  1  pipeline writeback enable
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline writeback data
- req_valid  in  NUM_REQ  secondary request valid, one bit per requester
- req_addr  in  NUM_REQ*5  destination registers, requester i at bits [5i+4:5i]
- req_data  in  NUM_REQ*32  result data, requester i at bits [32i+31:32i]
- req_ready  out  NUM_REQ  accept strobe, combinational, one-hot or zero
- rf_wen  out  1  register-file write enable, registered
- rf_addr  out  5  register-file write address, registered
- rf_wdata  out  32  register-file write data, registered
- pend_mask  out  32  bit r set while a valid FIFO entry targets r; bit 0 always 0
- stall_req  out  1  registered; pipeline must freeze while high
- buf_full  out  1  FIFO count == BUF_DEPTH

Behaviour:
- Reset (async, rst_n low):
  - rf_wen, rf_addr, rf_wdata, stall_req all 0.
  - FIFO empty, count 0, rr pointer 0, starve counter 0.
  - pend_mask and req_ready 0.
- Port winner per cycle:
  - If stall_req=1 and the FIFO is non-empty, the FIFO head wins and pipe inputs are ignored; the frozen pipeline re-presents them later.
  - Else if pipe_wen=1 and pipe_addr!=0, the pipeline wins.
  - Else if the FIFO is non-empty, the head wins.
  - Else no write.
- The winner is registered into rf_* at the next edge: latency 1 cycle for pipe writes, 1 cycle from head-of-FIFO. There is no bypass, so minimum secondary latency is 2 cycles from acceptance.
- pipe_wen with pipe_addr=0 produces rf_wen=0.
- Acceptance:
  - Grant goes to the first valid requester at or after the rr pointer (circular).
  - req_ready[g]=1 only if count<BUF_DEPTH, judged on the registered count. A same-cycle pop does not create room.
  - On acceptance the rr pointer moves to g+1 mod NUM_REQ; otherwise it holds.
  - At most one acceptance per cycle.
- An accepted request with addr 0 is consumed (ready=1) but not pushed.
- Simultaneous push and pop: count unchanged, entries stay in order.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head does not win.
  - Clears on a head pop or when the FIFO is empty.
  - When it reaches STARVE_LIMIT, stall_req is set at the next edge.
  - stall_req clears at the edge after the head pop that occurs during stall_req.
- pend_mask is combinational: the OR of one-hot(addr) over valid entries.
- Reset mid-operation discards all buffered entries and any in-flight rf_wen.

Optional Feature:
- Macro: WB_ARB_KILL_EN.
- Defined: when the pipeline wins with pipe_addr=r (r!=0), every valid FIFO entry with addr r is invalidated in that cycle, squashing the older write (write-after-write).
  - Invalid entries are skipped at pop without using a port cycle.
  - They still count toward capacity until popped.
  - They do not contribute to pend_mask.
- Undefined: no squashing. The hazard unit must prevent write-after-write conflicts using pend_mask.

Test Plan:
- Pipe only: pipe_wen=1, addr=5, data=0xDEADBEEF -> next cycle rf_wen=1, rf_addr=5, rf_wdata=0xDEADBEEF; with addr=0 -> rf_wen=0.
- Round-robin: both req_valid held high, pipe idle, addrs 3/4 -> accepts alternate req0, req1, req0; FIFO drains in acceptance order, first rf write 2 cycles after first accept.
- Full: BUF_DEPTH=2, pipe_wen=1 every cycle, 2 requests accepted -> buf_full=1, req_ready=0; pend_mask shows both addr bits.
- Starvation: same as the full case, continuing -> stall_req rises STARVE_LIMIT+1 cycles after the first wait; the head writes during stall and pipe data is ignored that cycle.
- Async reset mid-drain: rst_n low between edges with 2 entries -> all outputs 0 immediately; after release FIFO empty, rr=0.
- Kill (WB_ARB_KILL_EN): entry addr=7 buffered, pipe writes addr=7 -> pend_mask[7]=0 that cycle; entry never reaches rf; without macro it is written later.
